// File: rtl/mips_cpu_mem_port.sv
// Avalon-MM master for the CPU core: arbitrates data vs. fetch onto one bus,
// holds commands across waitrequest, returns read data with a one-cycle done pulse.
module mips_cpu_mem_port #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        stall,
  output logic        bus_err
);
  // state | meaning
  // IDLE  | no command; sample requests, data before fetch
  // DBUS  | data command on bus, held while waitrequest
  // IBUS  | fetch command on bus, held while waitrequest
  // DONE  | done pulse cycle; requests ignored, back to IDLE
  typedef enum logic [1:0] {IDLE, DBUS, IBUS, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            timed_out;
  logic            unused_addr_lsbs;

  // Counter reaching TIMEOUT-1 on a held cycle means this is the TIMEOUT-th held cycle.
  assign timed_out        = (cnt == CW'(TIMEOUT - 1));
  assign stall            = (d_read | d_write | if_req) & ~(d_done | if_done);
  assign unused_addr_lsbs = ^{d_addr[1:0], if_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      if_done        <= 1'b0;
      d_done         <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      bus_err        <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (d_read | d_write) begin
            avm_address    <= {d_addr[31:2], 2'b00};
            avm_byteenable <= d_byteenable;
            avm_writedata  <= d_wdata;
            avm_write      <= d_write;
            avm_read       <= ~d_write;
            state          <= DBUS;
          end else if (if_req) begin
            avm_address    <= {if_addr[31:2], 2'b00};
            avm_byteenable <= 4'b1111;
            avm_write      <= 1'b0;
            avm_read       <= 1'b1;
            state          <= IBUS;
          end
        end
        DBUS, IBUS: begin
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            state     <= DONE;
            if (state == IBUS) begin
              if_rdata <= avm_readdata;
              if_done  <= 1'b1;
            end else begin
              if (avm_read) d_rdata <= avm_readdata;
              d_done <= 1'b1;
            end
          end else if (timed_out) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            bus_err   <= 1'b1;
            state     <= DONE;
            if (state == IBUS) begin
              if_rdata <= '0;
              if_done  <= 1'b1;
            end else begin
              d_rdata <= '0;
              d_done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mips_cpu_mem_port.md
# mips_cpu_mem_port

Avalon-MM master port between the CPU core and the single external memory bus. It arbitrates between instruction fetch and the load/store unit's data accesses and holds each command stable across `waitrequest`. It captures read data and returns a one-cycle completion pulse to the requester. The core's stall logic uses `stall` to freeze the fetch/exec sequencer while a transfer is outstanding.

## Interface
- `TIMEOUT`, 1024: maximum cycles one command may be held under `waitrequest` before it is abandoned (must be ≥2).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `if_req` in 1: fetch request; level, held until `if_done`.
- `if_addr` in 32: fetch byte address.
- `if_rdata` out 32: fetched word, raw bus byte order; valid while `if_done`=1, then held.
- `if_done` out 1: one-cycle fetch completion pulse.
- `d_read` in 1: data read request; level, held until `d_done`.
- `d_write` in 1: data write request; level, held until `d_done`.
- `d_addr` in 32: data byte address.
- `d_byteenable` in 4: lane enables from load/store unit.
- `d_wdata` in 32: write data, already lane-swapped by load/store unit.
- `d_rdata` out 32: read word, raw bus byte order; valid while `d_done`=1, then held.
- `d_done` out 1: one-cycle data completion pulse.
- `avm_address` out 32: word-aligned bus address.
- `avm_read` out 1: bus read command.
- `avm_write` out 1: bus write command.
- `avm_byteenable` out 4: bus lane enables.
- `avm_writedata` out 32: bus write data.
- `avm_readdata` in 32: bus read data, valid in the cycle the command completes.
- `avm_waitrequest` in 1: slave stall.
- `stall` out 1: high whenever a request is pending or in flight.
- `bus_err` out 1: sticky timeout flag, cleared only by reset.

## Operation
- FSM states are IDLE, DBUS, IBUS and DONE. All `avm_*` outputs, `*_done`, `*_rdata` and `bus_err` are registered.
- In IDLE, a data request (`d_read|d_write`) has priority over `if_req`.
  - A data request latches `{d_addr[31:2],2'b00}`, `d_byteenable` and `d_wdata`, asserts `avm_write` if `d_write` else `avm_read`, and goes to DBUS.
  - Otherwise `if_req` latches `{if_addr[31:2],2'b00}`, byteenable 4'b1111 and `avm_read`, and goes to IBUS.
- If `d_read` and `d_write` are both high, the request is treated as a write.
- In DBUS/IBUS, all `avm_*` outputs stay frozen while `avm_waitrequest`=1.
- The first cycle with `avm_waitrequest`=0 completes the command:
  - Drop `avm_read`/`avm_write` next cycle.
  - Register `avm_readdata` into `d_rdata` or `if_rdata`. A write leaves `d_rdata` unchanged.
  - Pulse the matching `*_done` next cycle and enter DONE.
- DONE lasts exactly one cycle, the `*_done` cycle. Requests are ignored in DONE because the requester is still holding its level. The FSM then returns to IDLE.
- Timeout: a counter clears on command issue and increments each DBUS/IBUS cycle with `avm_waitrequest`=1. When it reaches `TIMEOUT`:
  - Drop the command.
  - Set `bus_err`=1.
  - Write 32'h0 to the matching `*_rdata`.
  - Pulse `*_done` and go to DONE.
- `stall` = `(d_read|d_write|if_req) & ~(d_done|if_done)`, combinational from inputs and registered done.
- Request inputs are sampled only in IDLE. Changes to address or data mid-transfer have no effect.

## Timing
- Reset values: `avm_read`=`avm_write`=0, `avm_address`=0, `avm_byteenable`=0, `avm_writedata`=0, `if_done`=`d_done`=0, `if_rdata`=`d_rdata`=0, `bus_err`=0. FSM resets to IDLE and the counter to 0.
- Request high at edge N (in IDLE) → command visible after edge N. With zero wait states, `*_done`=1 after edge N+1 and IDLE after edge N+2. Minimum transfer is 3 cycles.
- With k wait-state cycles, `*_done` is asserted k cycles later than the zero-wait case.
- Back-to-back: a new request sampled in the IDLE cycle after DONE issues immediately. There is no extra bubble.
- Reset asserted mid-transfer drops `avm_read`/`avm_write` asynchronously. No done pulse is produced.

## Test plan
- Zero-wait fetch: `if_req`=1, `if_addr`=0xBFC00002, `avm_readdata`=0x78563412 → `avm_address`=0xBFC00000 and `avm_byteenable`=4'hF for 1 cycle; `if_done` pulses 1 cycle with `if_rdata`=0x78563412.
- Write under 3 wait states: `d_write`, addr 0x1000_0005, be 4'b0010, data 0x0000AB00 → all `avm_*` stable for 4 cycles at address 0x1000_0004; `d_done` in cycle 6; `stall`=1 throughout until `d_done`.
- Simultaneous `if_req` and `d_read` in IDLE → data read issues first. The fetch issues in the IDLE cycle after `d_done`, with no bubble. Each requester receives exactly one done pulse.
- `TIMEOUT`=4 with `avm_waitrequest` stuck high on a read → command drops after 4 held cycles; `d_done`=1, `d_rdata`=0, `bus_err`=1 and staying 1 for subsequent good transfers.
- `rst_n` low during DBUS wait → `avm_read`=0 immediately, no `d_done`; after release the held request is re-issued from IDLE.
- `d_read`&`d_write` both high → `avm_write`=1, `avm_read`=0; `d_rdata` is unchanged on completion.
